// File: rtl/ax309_hex_scan.sv
// Six-digit multiplexed seven-segment driver for the AX309 board (active-low outputs).
// Optional HEX_SCAN_DECODE_EN adds per-digit hex-glyph decoding selected by ctrl[2+k].
module ax309_hex_scan #(
  parameter int CLK_HZ    = 50000000,
  parameter int SCAN_US   = 1000,
  parameter int BLANK_CLK = 64,
  parameter int NDIG      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_stb,
  input  logic [2:0] wr_adr,
  input  logic [7:0] wr_dat,
  output logic [7:0] seg_n,
  output logic [5:0] dig_n,
  output logic       frame
);
  localparam int ON_CLK  = (CLK_HZ / 1000000) * SCAN_US;
  localparam int CNT_MAX = (ON_CLK > BLANK_CLK) ? ON_CLK : BLANK_CLK;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic {BLANK, ON} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    dig_q [NDIG];
  logic [7:0]    ctrl;
  logic [7:0]    cur;
  logic          dec_k;
  logic [7:0]    lit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NDIG; k++) dig_q[k] <= 8'h00;
      ctrl <= 8'h01;
    end else if (wr_stb) begin
      if (wr_adr == 3'd6) ctrl <= wr_dat;
      for (int k = 0; k < NDIG; k++)
        if (wr_adr == 3'(k)) dig_q[k] <= wr_dat;
    end
  end

  always_comb begin
    cur   = 8'h00;
    dec_k = 1'b0;
    for (int k = 0; k < NDIG; k++)
      if (idx == 3'(k)) begin
        cur   = dig_q[k];
        dec_k = ctrl[2+k];
      end
  end

`ifdef HEX_SCAN_DECODE_EN
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
    endcase
  endfunction

  // Decoding at display time lets a ctrl toggle re-render already stored data.
  assign lit = dec_k ? {cur[7], glyph(cur[3:0])} : cur;
`else
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl[7:1], dec_k};
  assign lit = cur;
`endif

  // Outputs are registered from the current phase, so every change lands one clock later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= 3'(NDIG - 1);
      seg_n <= 8'hFF;
      dig_n <= 6'h3F;
      frame <= 1'b0;
    end else begin
      seg_n <= 8'hFF;
      dig_n <= 6'h3F;
      frame <= 1'b0;
      if (state == ON && ctrl[0]) begin
        seg_n <= ~lit;
        dig_n <= ~(6'b000001 << idx);
      end
      case (state)
        BLANK: begin
          if (cnt == '0) begin
            state <= ON;
            cnt   <= CW'(ON_CLK - 1);
          end else cnt <= cnt - CW'(1);
        end
        ON: begin
          if (cnt == '0) begin
            state <= BLANK;
            cnt   <= CW'(BLANK_CLK - 1);
            frame <= (idx == 3'd0);
            idx   <= (idx == 3'd0) ? 3'(NDIG - 1) : idx - 3'd1;
          end else cnt <= cnt - CW'(1);
        end
        default: state <= BLANK;
      endcase
    end
  end
endmodule

// File: tb/tb_ax309_hex_scan.sv
// Scoreboard bench for ax309_hex_scan: a cycle-position model pushes the expected
// output for the next clock, the sampled DUT output pops and compares it.
module tb_ax309_hex_scan;
  logic       clk = 1'b0;
  logic       rst_n, wr_stb;
  logic [2:0] wr_adr;
  logic [7:0] wr_dat;
  logic [7:0] seg_n;
  logic [5:0] dig_n;
  logic       frame;

  typedef struct packed {
    logic [7:0] seg;
    logic [5:0] dig;
    logic       fr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_dig [6];
  logic [7:0] m_ctrl;
  int         t = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  ax309_hex_scan #(.CLK_HZ(1000000), .SCAN_US(10), .BLANK_CLK(2), .NDIG(6)) dut (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .seg_n(seg_n), .dig_n(dig_n), .frame(frame));

  always #5 clk = ~clk;

  function automatic logic [6:0] gly(input logic [3:0] h);
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[h];
  endfunction

  // Frame = 6 slots of 12 clocks: 2 blank then 10 lit, digit 5 first.
  function automatic exp_t render(input int pos);
    exp_t       e;
    int         p, idx;
    logic [7:0] b;
    logic [5:0] one;
    one  = 6'b000001;
    p    = pos % 72;
    idx  = 5 - p / 12;
    e.fr = (p == 71);
    e.seg = 8'hFF;
    e.dig = 6'h3F;
    if ((p % 12) >= 2 && m_ctrl[0]) begin
      b = m_dig[idx];
`ifdef HEX_SCAN_DECODE_EN
      if (m_ctrl[2+idx]) b = {b[7], gly(b[3:0])};
`endif
      e.seg = ~b;
      e.dig = ~(one << idx);
    end
    return e;
  endfunction

  task automatic step(input logic rst, input logic stb, input logic [2:0] adr, input logic [7:0] dat);
    exp_t e;
    rst_n = rst; wr_stb = stb; wr_adr = adr; wr_dat = dat;
    if (!rst) sb.push_back(exp_t'{8'hFF, 6'h3F, 1'b0});
    else      sb.push_back(render(t + 1));
    if (!rst) begin
      for (int k = 0; k < 6; k++) m_dig[k] = 8'h00;
      m_ctrl = 8'h01;
      t = -1;
    end else if (stb) begin
      if (adr == 3'd6) m_ctrl = dat;
      else if (adr < 3'd6) m_dig[adr] = dat;
    end
    @(posedge clk);
    t++;
    @(negedge clk);
    e = sb.pop_front();
    n_assert++;
    assert (seg_n === e.seg) else begin
      n_fail++; $error("FAIL seg_n t=%0d observed %h expected %h", t, seg_n, e.seg);
    end
    n_assert++;
    assert (dig_n === e.dig) else begin
      n_fail++; $error("FAIL dig_n t=%0d observed %h expected %h", t, dig_n, e.dig);
    end
    n_assert++;
    assert (frame === e.fr) else begin
      n_fail++; $error("FAIL frame t=%0d observed %b expected %b", t, frame, e.fr);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [7:0] dat);
    step(1'b1, 1'b1, adr, dat);
  endtask

  // Advance until the next write lands in cycle position p of the frame (at most 72 clocks).
  task automatic goto_pos(input int p);
    for (int i = 0; i < 72 && (t % 72) != p; i++) idle(1);
  endtask

  initial begin
    rst_n = 1'b0; wr_stb = 1'b0; wr_adr = 3'd0; wr_dat = 8'h00;
    for (int k = 0; k < 6; k++) m_dig[k] = 8'h00;
    m_ctrl = 8'h01;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 8'h00);
    idle(150);
    wr(3'd0, 8'h3F);
    wr(3'd5, 8'h86);
    wr(3'd4, 8'hFF);
    wr(3'd1, 8'h01);
    idle(150);
    goto_pos(20);
    wr(3'd6, 8'h00);
    idle(100);
    goto_pos(64);
    wr(3'd6, 8'h01);
    idle(80);
    goto_pos(28);
    wr(3'd7, 8'hAA);
    idle(2);
    wr(3'd3, 8'h5B);
    idle(3);
    wr(3'd2, 8'h80);
    idle(100);
    goto_pos(40);
    step(1'b0, 1'b0, 3'd0, 8'h00);
    idle(90);
    wr(3'd5, 8'h49);
    idle(20);
`ifdef HEX_SCAN_DECODE_EN
    wr(3'd6, 8'h07);
    wr(3'd0, 8'h8A);
    idle(80);
    goto_pos(66);
    wr(3'd6, 8'h03);
    idle(80);
    wr(3'd6, 8'hFD);
    wr(3'd4, 8'h7B);
    idle(80);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
